// File: rtl/iob_bus_arbiter_pkg.sv
// Shared definitions for the two-requester IOb native bus arbiter.
// Native bus layout (MSB first):
//   request  : valid | address | wdata | wstrb   (REQ_W  = 1 + ADDR_W + DATA_W + DATA_W/8)
//   response : rdata | ready                     (RESP_W = DATA_W + 1)
// The helper functions below give field widths and bit positions so every
// file slices the flat buses the same way.
package iob_bus_arbiter_pkg;

    localparam int unsigned IOB_ADDR_W_DEF = 32;
    localparam int unsigned IOB_DATA_W_DEF = 32;

    // Arbiter control state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Byte-strobe width for a given data width.
    function automatic int unsigned iob_strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Total width of the flat request bus.
    function automatic int unsigned iob_req_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Total width of the flat response bus.
    function automatic int unsigned iob_resp_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

    // LSB position of the address field inside the request bus.
    function automatic int unsigned iob_addr_lsb(input int unsigned data_w);
        return data_w + data_w / 8;
    endfunction

    // LSB position of the wdata field inside the request bus.
    function automatic int unsigned iob_wdata_lsb(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-way round-robin pick.
// A single valid requester wins outright; on a tie the requester that did
// not own the bus last time wins.
// Ports:
//   valid  : request valid per requester (bit i = requester i)
//   last   : index of the previous owner
//   any_c  : at least one requester is valid
//   pick_c : index of the winning requester (meaningful when any_c is set)
module iob_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       any_c,
    output logic       pick_c
);

    // Tie goes to the requester that did not win last time.
    always_comb begin
        any_c  = |valid;
        pick_c = valid[1];
        if (valid[0] && valid[1]) begin
            pick_c = ~last;
        end
    end

endmodule

// File: rtl/iob_bus_arbiter.sv
// Shares one native IOb memory port between two requesters (typically CPU
// instruction bus on M0 and data bus on M1). One transaction in flight; the
// winner's request is captured at grant and replayed to the slave from
// registers until the slave answers ready.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   m0_req, m1_req   : requester buses  valid|address|wdata|wstrb
//   m0_resp, m1_resp : requester responses rdata|ready
//   s_req, s_resp    : shared slave request / response
//   grant            : index of current/last owner (0=M0, 1=M1)
//   busy             : transaction outstanding on the slave port
module iob_bus_arbiter
    import iob_bus_arbiter_pkg::*;
#(
    parameter  int unsigned ADDR_W = IOB_ADDR_W_DEF,
    parameter  int unsigned DATA_W = IOB_DATA_W_DEF,
    localparam int unsigned REQ_W  = iob_req_w(ADDR_W, DATA_W),
    localparam int unsigned RESP_W = iob_resp_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  m0_req,
    output logic [RESP_W-1:0] m0_resp,
    input  logic [REQ_W-1:0]  m1_req,
    output logic [RESP_W-1:0] m1_resp,
    output logic [REQ_W-1:0]  s_req,
    input  logic [RESP_W-1:0] s_resp,
    output logic              grant,
    output logic              busy
);

    localparam int unsigned STRB_W    = iob_strb_w(DATA_W);
    localparam int unsigned ADDR_LSB  = iob_addr_lsb(DATA_W);
    localparam int unsigned WDATA_LSB = iob_wdata_lsb(DATA_W);

    arb_state_e        state_q;
    logic              busy_q;
    logic              grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic [STRB_W-1:0] req_wstrb [2];

    logic              any_c;
    logic              pick_c;
    logic              s_ready;
    logic [DATA_W-1:0] s_rdata;
    logic              done_c;
    logic              hold_viol_c;

    // Unpack the two requester buses into per-requester fields.
    assign req_valid[0] = m0_req[REQ_W-1];
    assign req_valid[1] = m1_req[REQ_W-1];
    assign req_addr[0]  = m0_req[ADDR_LSB +: ADDR_W];
    assign req_addr[1]  = m1_req[ADDR_LSB +: ADDR_W];
    assign req_wdata[0] = m0_req[WDATA_LSB +: DATA_W];
    assign req_wdata[1] = m1_req[WDATA_LSB +: DATA_W];
    assign req_wstrb[0] = m0_req[0 +: STRB_W];
    assign req_wstrb[1] = m1_req[0 +: STRB_W];

    assign s_ready = s_resp[0];
    assign s_rdata = s_resp[RESP_W-1 -: DATA_W];

    iob_rr_arb2 u_rr_arb2 (
        .valid  (req_valid),
        .last   (grant_q),
        .any_c  (any_c),
        .pick_c (pick_c)
    );

    // Grant/complete FSM with the captured request register.
    // grant resets to 1 so that M0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            grant_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_c) begin
                        addr_q  <= req_addr[pick_c];
                        wdata_q <= req_wdata[pick_c];
                        wstrb_q <= req_wstrb[pick_c];
                        grant_q <= pick_c;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (s_ready) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Slave request comes only from registers; valid is the busy flag.
    assign s_req = {busy_q, addr_q, wdata_q, wstrb_q};
    assign grant = grant_q;
    assign busy  = busy_q;

    // Slave ready is forwarded to the owner in the same cycle; everyone
    // else sees an all-zero response.
    assign done_c  = busy_q & s_ready;
    assign m0_resp = (done_c && !grant_q) ? {s_rdata, 1'b1} : '0;
    assign m1_resp = (done_c &&  grant_q) ? {s_rdata, 1'b1} : '0;

    // Owner dropped or altered its request while its transaction is pending.
    // Harmless to the hardware (the captured copy completes), but it points
    // at a requester bug.
    assign hold_viol_c = busy_q &&
                         (!req_valid[grant_q]             ||
                          (req_addr[grant_q]  != addr_q)  ||
                          (req_wdata[grant_q] != wdata_q) ||
                          (req_wstrb[grant_q] != wstrb_q));

    a_owner_holds_request : assert property (@(posedge clk) disable iff (rst) !hold_viol_c)
        else $warning("iob_bus_arbiter: owner request changed while busy");

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Self-checking bench for iob_bus_arbiter: directed scenarios plus a
// randomized run, checked against a transaction-level model of the
// arbitration rules (single valid wins, tie goes to the non-last owner).
module tb_iob_bus_arbiter;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned REQ_W  = 1 + AW + DW + SW;
    localparam int unsigned RESP_W = DW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [REQ_W-1:0]  m0_req;
    logic [REQ_W-1:0]  m1_req;
    logic [REQ_W-1:0]  s_req;
    logic [RESP_W-1:0] m0_resp;
    logic [RESP_W-1:0] m1_resp;
    logic [RESP_W-1:0] s_resp;
    logic              grant;
    logic              busy;

    int checks   = 0;
    int errors   = 0;
    int viol_cnt = 0;
    int last_g   = 1;

    // Requester-side view of what each master is currently asking for.
    bit          pv [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    logic [SW-1:0] ps [2];

    iob_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_req  (m0_req),
        .m0_resp (m0_resp),
        .m1_req  (m1_req),
        .m1_resp (m1_resp),
        .s_req   (s_req),
        .s_resp  (s_resp),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Count cycles in which the hold-request assertion condition is raised.
    always @(negedge clk) begin
        if (rst === 1'b0 && dut.hold_viol_c === 1'b1) viol_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        m0_req = {pv[0], pa[0], pd[0], ps[0]};
        m1_req = {pv[1], pa[1], pd[1], ps[1]};
    endtask

    task automatic set_req(input int m, input bit v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        pv[m] = v;
        pa[m] = a;
        pd[m] = d;
        ps[m] = s;
        drive();
    endtask

    task automatic set_rand(input int m);
        set_req(m, 1'b1, AW'($urandom), DW'($urandom), SW'($urandom_range(0, 15)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_req"},   s_req,   '0);
        check({tag, "_grant"},   grant,   1);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_m0_resp"}, m0_resp, '0);
        check({tag, "_m1_resp"}, m1_resp, '0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        last_g = 1;
        step();
    endtask

    // One complete transaction. Entered in an IDLE cycle with requests set;
    // returns in the following mandatory idle cycle with slave ready low.
    task automatic serve(input int lat, input bit mutate, input logic [DW-1:0] rd, output int o);
        logic [REQ_W-1:0]  exp_req;
        logic [RESP_W-1:0] exp_resp;
        if (pv[0] && pv[1]) o = 1 - last_g;
        else                o = pv[1] ? 1 : 0;
        exp_req  = {1'b1, pa[o], pd[o], ps[o]};
        exp_resp = {rd, 1'b1};
        step();
        check("grant", grant, o);
        check("busy_on", busy, 1);
        check("s_req", s_req, exp_req);
        if (mutate) set_req(o, 1'b1, pa[o] ^ AW'(4), pd[o], ps[o]);
        for (int i = 0; i < lat; i++) begin
            check("wait_m0_resp", m0_resp, '0);
            check("wait_m1_resp", m1_resp, '0);
            step();
            check("hold_s_req", s_req, exp_req);
            check("hold_busy", busy, 1);
        end
        s_resp = {rd, 1'b1};
        #1;
        check("owner_resp", (o == 0) ? m0_resp : m1_resp, exp_resp);
        check("other_resp", (o == 0) ? m1_resp : m0_resp, '0);
        step();
        s_resp = '0;
        #1;
        check("busy_off", busy, 0);
        check("s_valid_off", s_req[REQ_W-1], 0);
        check("idle_m0_resp", m0_resp, '0);
        check("idle_m1_resp", m1_resp, '0);
        last_g = o;
    endtask

    initial begin
        int o;
        int v0;
        rst    = 1'b1;
        s_resp = '0;
        for (int m = 0; m < 2; m++) set_req(m, 1'b0, '0, '0, '0);
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        step();
        check("idle_busy", busy, 0);

        // Single M0 read with a slow slave.
        set_req(0, 1'b1, AW'(32'h100), '0, '0);
        serve(3, 1'b0, DW'(32'hDEADBEEF), o);
        check("t1_owner", o, 0);
        set_req(0, 1'b0, '0, '0, '0);
        check("t1_no_viol", viol_cnt, 0);

        // Repeated ties from reset alternate 0,1,0,1.
        reset_dut();
        set_rand(0);
        set_rand(1);
        for (int r = 0; r < 4; r++) begin
            serve(int'($urandom_range(0, 3)), 1'b0, DW'($urandom), o);
            check("t2_rr_seq", o, r % 2);
            set_rand(o);
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        step();

        // M1 write; the owner alters its address mid-transaction.
        set_req(1, 1'b1, AW'(32'h200), DW'(32'h12345678), SW'(4'hF));
        v0 = viol_cnt;
        serve(2, 1'b1, DW'($urandom), o);
        check("t3_owner", o, 1);
        check("t3_viol_fired", viol_cnt > v0, 1);
        set_req(1, 1'b0, '0, '0, '0);

        // Slave ready in the first busy cycle.
        set_req(0, 1'b1, AW'(32'h340), '0, '0);
        serve(0, 1'b0, DW'(32'hA5A5_0F0F), o);
        check("t4_owner", o, 0);
        set_req(0, 1'b0, '0, '0, '0);

        // Reset while M1 owns the bus, M0 waiting.
        set_req(1, 1'b1, AW'(32'h500), DW'($urandom), SW'(4'h3));
        step();
        check("t5_grant_m1", grant, 1);
        check("t5_busy", busy, 1);
        set_req(0, 1'b1, AW'(32'h600), '0, '0);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_midrst");
        @(negedge clk);
        rst = 1'b0;
        last_g = 1;
        set_req(1, 1'b0, '0, '0, '0);
        serve(1, 1'b0, DW'($urandom), o);
        check("t5_owner", o, 0);
        set_req(0, 1'b0, '0, '0, '0);

        // Continuous M0 traffic; a single M1 request still gets in.
        set_rand(0);
        serve(1, 1'b0, DW'($urandom), o);
        check("t6_first", o, 0);
        set_rand(0);
        set_rand(1);
        serve(2, 1'b0, DW'($urandom), o);
        check("t6_m1_in", o, 1);
        set_req(1, 1'b0, '0, '0, '0);
        serve(0, 1'b0, DW'($urandom), o);
        check("t6_m0_back", o, 0);
        set_req(0, 1'b0, '0, '0, '0);

        // Random traffic: pending requests persist until served.
        v0 = viol_cnt;
        for (int r = 0; r < 60; r++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pv[m] && $urandom_range(0, 1) == 1) set_rand(m);
            end
            if (!pv[0] && !pv[1]) set_rand(int'($urandom_range(0, 1)));
            serve(int'($urandom_range(0, 4)), 1'b0, DW'($urandom), o);
            if ($urandom_range(0, 1) == 1) set_rand(o);
            else                           set_req(o, 1'b0, '0, '0, '0);
        end
        check("rand_no_viol", viol_cnt, v0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
